// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-port, word-addressed 32-bit data memory.
// It converts byte addresses to word addresses, extends loads and does sub-word stores by read-modify-write.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rw,
    output logic [31:0] mem_ain,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DATA,
        WR,
        DONE
    } state_t;

    state_t      state_reg, state_next;

    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wword_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;

    logic        accept;
    logic        width_ok;
    logic        align_ok;
    logic        range_ok;
    logic        req_bad;
    logic [31:0] word_addr;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [3:0]  lane_sel;
    logic [31:0] merged_word;

    assign accept    = req_valid && (state_reg == IDLE);
    assign word_addr = {2'b00, addr_reg[31:2]};
    assign range_ok  = ({2'b00, req_addr[31:2]} < MEM_WORDS);
    assign req_bad   = !(width_ok && align_ok && range_ok);

    // Unsigned widths (100/101) exist only for loads.
    always_comb begin
        width_ok = 1'b0;
        align_ok = 1'b0;
        case (req_funct3)
            3'b000: begin
                width_ok = 1'b1;
                align_ok = 1'b1;
            end
            3'b001: begin
                width_ok = 1'b1;
                align_ok = ~req_addr[0];
            end
            3'b010: begin
                width_ok = 1'b1;
                align_ok = (req_addr[1:0] == 2'b00);
            end
            3'b100: begin
                width_ok = ~req_we;
                align_ok = 1'b1;
            end
            3'b101: begin
                width_ok = ~req_we;
                align_ok = ~req_addr[0];
            end
            default: begin
                width_ok = 1'b0;
                align_ok = 1'b0;
            end
        endcase
    end

    assign lane_byte = mem_dout[{addr_reg[1:0], 3'b000} +: 8];
    assign lane_half = mem_dout[{addr_reg[1], 4'b0000} +: 16];

    always_comb begin
        load_data = mem_dout;
        case (funct3_reg)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'h000000, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'h0000, lane_half};
            default: load_data = mem_dout;
        endcase
    end

    // Store lane merge: funct3_reg[0] distinguishes SH from SB on the RMW path.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_sel[gi] = funct3_reg[0] ? (addr_reg[1] == LANE[1])
                                                : (addr_reg[1:0] == LANE);
            assign merged_word[8*gi +: 8] =
                !lane_sel[gi]  ? mem_dout[8*gi +: 8] :
                funct3_reg[0]  ? wword_reg[8*(gi % 2) +: 8] :
                                 wword_reg[7:0];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Memory-side outputs decode straight from the state so an asynchronous
    // reset drops mem_rw before the next edge and no write can commit.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_rw     = 1'b0;
        mem_ain    = 32'h0;
        mem_din    = 32'h0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_next = DONE;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                mem_ain    = word_addr;
                state_next = DATA;
            end
            DATA: begin
                mem_ain    = word_addr;
                state_next = we_reg ? WR : DONE;
            end
            WR: begin
                mem_rw     = 1'b1;
                mem_ain    = word_addr;
                mem_din    = wword_reg;
                state_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_reg         <= 1'b0;
            funct3_reg     <= 3'b000;
            addr_reg       <= 32'h0;
            wword_reg      <= 32'h0;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                wword_reg  <= req_wdata;
            end
            if ((state_reg == DATA) && we_reg) begin
                wword_reg <= merged_word;
            end
            // Response fields change only on entry to DONE and hold afterwards.
            if ((state_next == DONE) && (state_reg != DONE)) begin
                resp_rdata_reg <= (state_reg == DATA) ? load_data : 32'h0;
                resp_err_reg   <= (state_reg == IDLE);
            end
        end
    end

    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a registered-read word memory model.
// Table vectors cover loads, stores and errors; a hand sequence covers reset abort.
module tb_mem_access_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rw;
    logic [31:0] mem_ain;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    int checks;
    int errors;

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_rw     (mem_rw),
        .mem_ain    (mem_ain),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_rw) begin
            mem[mem_ain[9:0]] <= mem_din;
        end else begin
            mem_dout <= mem[mem_ain[9:0]];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          rw;
        logic [31:0] din;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    int          obs_lat;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_rw;
    logic [31:0] obs_din;
    logic [31:0] obs_ain;
    logic [31:0] obs_first_ain;
    int          obs_ready_bad;
    logic        obs_ready_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bit got;
        @(negedge clock);
        obs_ready_start = req_ready;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clock);
        #1;
        req_valid     = 1'b0;
        obs_lat       = 99;
        obs_rdata     = 32'hxxxxxxxx;
        obs_err       = 1'bx;
        obs_rw        = 0;
        obs_din       = 32'h0;
        obs_ain       = 32'h0;
        obs_first_ain = 32'hxxxxxxxx;
        obs_ready_bad = 0;
        got           = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clock);
            if (c == 1) obs_first_ain = mem_ain;
            if (req_ready) obs_ready_bad++;
            if (mem_rw) begin
                obs_rw++;
                obs_din = mem_din;
                obs_ain = mem_ain;
            end
            if (resp_valid) begin
                obs_lat   = c;
                obs_rdata = resp_rdata;
                obs_err   = resp_err;
                got       = 1'b1;
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        pre_we     = 1'b0;
        pre_addr   = 10'd0;
        pre_data   = 32'h0;

        //          we    f3      addr          wdata         lat rdata         err  rw din
        vecs[0]  = '{1'b0, 3'b010, 32'h00000010, 32'h0,        3, 32'h8899AABB, 1'b0, 0, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h00000013, 32'h0,        3, 32'hFFFFFF88, 1'b0, 0, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h00000013, 32'h0,        3, 32'h00000088, 1'b0, 0, 32'h0};
        vecs[3]  = '{1'b0, 3'b001, 32'h00000012, 32'h0,        3, 32'hFFFF8899, 1'b0, 0, 32'h0};
        vecs[4]  = '{1'b0, 3'b101, 32'h00000010, 32'h0,        3, 32'h0000AABB, 1'b0, 0, 32'h0};
        vecs[5]  = '{1'b1, 3'b000, 32'h00000011, 32'h123456CC, 4, 32'h0,        1'b0, 1, 32'h8899CCBB};
        vecs[6]  = '{1'b0, 3'b010, 32'h00000010, 32'h0,        3, 32'h8899CCBB, 1'b0, 0, 32'h0};
        vecs[7]  = '{1'b1, 3'b010, 32'h00000020, 32'hDEADBEEF, 2, 32'h0,        1'b0, 1, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 3'b010, 32'h00000020, 32'h0,        3, 32'hDEADBEEF, 1'b0, 0, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'h00000012, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0};
        vecs[10] = '{1'b1, 3'b001, 32'h00000001, 32'h5555AAAA, 1, 32'h0,        1'b1, 0, 32'h0};
        vecs[11] = '{1'b0, 3'b011, 32'h00000000, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0};
        vecs[12] = '{1'b0, 3'b010, 32'h00001000, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0};
        vecs[13] = '{1'b1, 3'b001, 32'h00000022, 32'h00001234, 4, 32'h0,        1'b0, 1, 32'h1234BEEF};
        vecs[14] = '{1'b0, 3'b001, 32'h00000022, 32'h0,        3, 32'h00001234, 1'b0, 0, 32'h0};
        vecs[15] = '{1'b0, 3'b000, 32'h00000020, 32'h0,        3, 32'hFFFFFFEF, 1'b0, 0, 32'h0};
        vecs[16] = '{1'b1, 3'b100, 32'h00000000, 32'h00000077, 1, 32'h0,        1'b1, 0, 32'h0};
        vecs[17] = '{1'b1, 3'b010, 32'h00000FFC, 32'h0BADF00D, 2, 32'h0,        1'b0, 1, 32'h0BADF00D};
        vecs[18] = '{1'b0, 3'b010, 32'h00000FFC, 32'h0,        3, 32'h0BADF00D, 1'b0, 0, 32'h0};

        // Preload word 4 while the unit is still held in reset.
        @(negedge clock);
        pre_we   = 1'b1;
        pre_addr = 10'd4;
        pre_data = 32'h8899AABB;
        @(negedge clock);
        pre_we = 1'b0;

        check("reset_req_ready",  {31'd0, req_ready},  32'd1);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_resp_err",   {31'd0, resp_err},   32'd0);
        check("reset_mem_rw",     {31'd0, mem_rw},     32'd0);
        check("reset_mem_ain",    mem_ain,             32'h0);
        check("reset_mem_din",    mem_din,             32'h0);
        check("reset_resp_rdata", resp_rdata,          32'h0);

        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            $display("txn %0d we=%0b f3=%03b addr=%h wdata=%h lat=%0d rdata=%h err=%0b rw=%0d",
                     i, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                     obs_lat, obs_rdata, obs_err, obs_rw);
            check($sformatf("v%0d_ready_at_start", i), {31'd0, obs_ready_start}, 32'd1);
            check($sformatf("v%0d_latency", i), obs_lat, vecs[i].lat);
            check($sformatf("v%0d_rdata", i), obs_rdata, vecs[i].rdata);
            check($sformatf("v%0d_err", i), {31'd0, obs_err}, {31'd0, vecs[i].err});
            check($sformatf("v%0d_rw_pulses", i), obs_rw, vecs[i].rw);
            check($sformatf("v%0d_ready_busy", i), obs_ready_bad, 32'd0);
            check($sformatf("v%0d_first_ain", i), obs_first_ain,
                  vecs[i].err ? 32'h0 : {2'b00, vecs[i].addr[31:2]});
            if (vecs[i].rw != 0) begin
                check($sformatf("v%0d_wr_din", i), obs_din, vecs[i].din);
                check($sformatf("v%0d_wr_ain", i), obs_ain, {2'b00, vecs[i].addr[31:2]});
            end
        end

        // Reset during DATA of an SB: no write, no response, memory word unchanged.
        begin
            int rw_seen;
            int vld_seen;
            rw_seen  = 0;
            vld_seen = 0;
            @(negedge clock);
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b000;
            req_addr   = 32'h00000011;
            req_wdata  = 32'h000000FF;
            @(posedge clock);
            #1;
            req_valid = 1'b0;
            @(negedge clock);
            @(negedge clock);
            reset_n = 1'b0;
            #1;
            check("abort_rw_immediate", {31'd0, mem_rw}, 32'd0);
            check("abort_ready_immediate", {31'd0, req_ready}, 32'd1);
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                if (mem_rw) rw_seen++;
                if (resp_valid) vld_seen++;
            end
            reset_n = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clock);
                if (mem_rw) rw_seen++;
                if (resp_valid) vld_seen++;
            end
            check("abort_rw_pulses", rw_seen, 32'd0);
            check("abort_resp_valid", vld_seen, 32'd0);
            check("abort_ready_after", {31'd0, req_ready}, 32'd1);
            check("abort_mem_word4", mem[4], 32'h8899CCBB);
            $display("txn abort sb addr=00000011 rw_seen=%0d resp_seen=%0d", rw_seen, vld_seen);
        end

        // The unit still works after the aborted access.
        do_req(1'b0, 3'b010, 32'h00000010, 32'h0);
        $display("txn post_abort lw addr=00000010 lat=%0d rdata=%h err=%0b", obs_lat, obs_rdata, obs_err);
        check("post_abort_latency", obs_lat, 32'd3);
        check("post_abort_rdata", obs_rdata, 32'h8899CCBB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the single-port data memory: accepts byte-addressed load/store requests from the core, drives the memory's `rw`/`ain`/`din` port, and returns load data.
- The memory is 32-bit, word-addressed, with a registered read (data valid the cycle after the address is presented with `rw=0`) and a write on the clock edge when `rw=1`.
- This block converts byte addresses to word addresses and performs RISC-V sub-word extraction and sign/zero extension.
- Sub-word stores are done by read-modify-write; misaligned, illegal or out-of-range accesses are flagged as errors.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the attached memory; word addresses >= MEM_WORDS are errors.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V width/sign code
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle pulse, access complete
- resp_rdata  output  32  extended load data (0 for stores and errors)
- resp_err  output  1  qualifies resp_valid: misaligned/illegal/out-of-range
- mem_rw  output  1  to memory rw; 1 = write
- mem_ain  output  32  to memory ain; word address = req_addr >> 2
- mem_din  output  32  to memory din
- mem_dout  input  32  from memory dout

Behaviour:
- Clock is `clock`; reset is `reset_n`, asynchronous, active-low.
- Reset values:
  - state = IDLE
  - resp_valid, resp_err, mem_rw = 0
  - resp_rdata, mem_ain, mem_din = 0
  - all latched request registers = 0
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. All request fields are latched at that edge. No new request is accepted until the unit returns to IDLE (the cycle after DONE).
- Loads, by funct3:
  - 000 LB, 100 LBU: any alignment
  - 001 LH, 101 LHU: addr[0] = 0
  - 010 LW: addr[1:0] = 0
- Stores, by funct3:
  - 000 SB: any alignment
  - 001 SH: addr[0] = 0
  - 010 SW: addr[1:0] = 0
- Error conditions, detected at accept: any other funct3, misalignment, or (req_addr >> 2) >= MEM_WORDS.
- FSM states: IDLE, RD, DATA, WR, DONE.
  - IDLE -> DONE on an error; no memory write occurs.
  - IDLE -> WR for SW.
  - IDLE -> RD for all loads, SB and SH.
  - RD: mem_rw = 0, mem_ain = word address. -> DATA.
  - DATA: mem_dout holds the addressed word.
    - Load: extract the lane, extend it, register into resp_rdata. -> DONE.
    - SB/SH: merge req_wdata into the lane and register it as the write word. -> WR.
  - WR: mem_rw = 1, mem_ain = word address, mem_din = write word (req_wdata for SW). -> DONE.
  - DONE: resp_valid = 1 for exactly one cycle; resp_err is set if this was an error access. -> IDLE.
- Lane selection (little-endian):
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane]
  - halfword lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]]
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW is unmodified.
- RMW store: unselected lanes keep the mem_dout value read in DATA; the selected lane takes req_wdata[7:0] or req_wdata[15:0].
- Latency, counted from the accept edge to the resp_valid cycle:
  - load: 3 cycles
  - SW: 2 cycles
  - SB/SH: 4 cycles
  - error: 1 cycle
- mem_rw is high only in WR, never for more than one cycle per request. Outside RD/DATA/WR, mem_ain and mem_din = 0.
- resp_rdata and resp_err hold their values after DONE until the next DONE overwrites them; resp_rdata = 0 for stores.
- Reset asserted mid-operation immediately forces mem_rw = 0 and state = IDLE. No response is produced for the aborted request. If reset arrives in WR before the edge, no write commits.

Test Plan:
- Preload word 4 = 0x8899AABB; LW addr 0x10 -> mem_ain = 4 in RD; resp_valid 3 cycles after accept; resp_rdata = 0x8899AABB, resp_err = 0.
- LB addr 0x13 -> 0xFFFFFF88; LBU addr 0x13 -> 0x00000088; LH addr 0x12 -> 0xFFFF8899; LHU addr 0x10 -> 0x0000AABB.
- SB addr 0x11, wdata 0x123456CC -> exactly one mem_rw pulse, mem_din = 0x8899CCBB, resp_valid 4 cycles after accept; a following LW addr 0x10 returns 0x8899CCBB.
- SW addr 0x20, wdata 0xDEADBEEF -> no RD cycle; mem_rw = 1 with mem_ain = 8 for one cycle; resp_valid 2 cycles after accept.
- Each of LW addr 0x12, SH addr 0x01, funct3 = 011, and LW addr 0x1000 (word 1024) -> resp_err = 1 one cycle after accept, mem_rw never asserted, resp_rdata = 0.
- Assert reset_n = 0 during the DATA state of an SB -> mem_rw stays 0, no resp_valid, req_ready = 1 after release; memory word unchanged. Also check req_ready = 0 from accept through DONE, and back-to-back requests are accepted one cycle after resp_valid.
